// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types, widths and grant helper for the 2:1 Wishbone arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_e;

    typedef logic [0:0] master_idx_t;

    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    // On a tie the master that did not own the previous CYC period wins.
    function automatic master_idx_t pick_grant(
        input logic        req0,
        input logic        req1,
        input master_idx_t last_grant
    );
        if (req0 && req1) begin
            return ~last_grant;
        end else if (req0) begin
            return 1'b0;
        end else begin
            return 1'b1;
        end
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// rtl/wb_watchdog.sv - cycle watchdog: flags the cycle in which the counter would reach TIMEOUT_CYCLES
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic             WD_ON    = (TIMEOUT_CYCLES > 0);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A clear in the same cycle (ack/err) always beats expiry.
    assign expired_o = WD_ON && en_i && !clear_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/wb_arbiter_2to1.sv
// rtl/wb_arbiter_2to1.sv - two-master round-robin pipelined Wishbone arbiter with CYC lock and watchdog abort
module wb_arbiter_2to1
    import wb_arb_pkg::*;
#(
    parameter int ADR_W          = 28,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic             m0_stall_o,
    output logic [DAT_W-1:0] m0_dat_o,

    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             m1_stall_o,
    output logic [DAT_W-1:0] m1_dat_o,

    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_stall_i,
    input  logic [DAT_W-1:0] s_dat_i
);

    arb_state_e  state_q;
    master_idx_t owner_q;
    master_idx_t last_grant_q;

    logic             own_cyc;
    logic             own_stb;
    logic             own_we;
    logic [ADR_W-1:0] own_adr;
    logic [SEL_W-1:0] own_sel;
    logic [DAT_W-1:0] own_dat;
    logic             wd_expired;

    assign own_cyc = owner_q[0] ? m1_cyc_i : m0_cyc_i;
    assign own_stb = owner_q[0] ? m1_stb_i : m0_stb_i;
    assign own_we  = owner_q[0] ? m1_we_i  : m0_we_i;
    assign own_adr = owner_q[0] ? m1_adr_i : m0_adr_i;
    assign own_sel = owner_q[0] ? m1_sel_i : m0_sel_i;
    assign own_dat = owner_q[0] ? m1_dat_i : m0_dat_i;

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    wb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  ((state_q != BUSY) || s_ack_i || s_err_i),
        .en_i     (state_q == BUSY),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_cyc_i || m1_cyc_i) begin
                        owner_q <= pick_grant(m0_cyc_i, m1_cyc_i, last_grant_q);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    // Release takes priority over a coincident watchdog expiry.
                    if (!own_cyc) begin
                        state_q      <= IDLE;
                        last_grant_q <= owner_q;
                    end else if (wd_expired) begin
                        state_q <= ABORT;
                    end
                end
                ABORT: begin
                    state_q      <= IDLE;
                    last_grant_q <= owner_q;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_sel_o    = '0;
        s_dat_o    = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_stall_o = 1'b1;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_stall_o = 1'b1;
        case (state_q)
            BUSY: begin
                s_cyc_o = own_cyc;
                s_stb_o = own_stb;
                s_we_o  = own_we;
                s_adr_o = own_adr;
                s_sel_o = own_sel;
                s_dat_o = own_dat;
                if (owner_q[0]) begin
                    m1_ack_o   = s_ack_i;
                    m1_err_o   = s_err_i;
                    m1_stall_o = s_stall_i;
                end else begin
                    m0_ack_o   = s_ack_i;
                    m0_err_o   = s_err_i;
                    m0_stall_o = s_stall_i;
                end
            end
            ABORT: begin
                if (owner_q[0]) begin
                    m1_err_o = 1'b1;
                end else begin
                    m0_err_o = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2to1.sv
// tb/tb_wb_arbiter_2to1.sv - table-driven scoreboard bench for wb_arbiter_2to1
module tb_wb_arbiter_2to1;

    localparam int ADR_W = 28;
    localparam int TO    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             m0_cyc_i, m0_stb_i, m0_we_i;
    logic [ADR_W-1:0] m0_adr_i;
    logic [3:0]       m0_sel_i;
    logic [31:0]      m0_dat_i;
    logic             m0_ack_o, m0_err_o, m0_stall_o;
    logic [31:0]      m0_dat_o;
    logic             m1_cyc_i, m1_stb_i, m1_we_i;
    logic [ADR_W-1:0] m1_adr_i;
    logic [3:0]       m1_sel_i;
    logic [31:0]      m1_dat_i;
    logic             m1_ack_o, m1_err_o, m1_stall_o;
    logic [31:0]      m1_dat_o;
    logic             s_cyc_o, s_stb_o, s_we_o;
    logic [ADR_W-1:0] s_adr_o;
    logic [3:0]       s_sel_o;
    logic [31:0]      s_dat_o;
    logic             s_ack_i, s_err_i, s_stall_i;
    logic [31:0]      s_dat_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter_2to1 #(.ADR_W(ADR_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m0_stall_o(m0_stall_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .m1_stall_o(m1_stall_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .s_stall_i(s_stall_i), .s_dat_i(s_dat_i)
    );

    // cyc = {m1,m0}; sl = {ack,err,stall}; mir: 0 bus zero, 1 m0, 2 m1, 3 unchecked; eN = {ack,err,stall}
    typedef struct {
        logic [1:0] cyc;
        logic [2:0] sl;
        logic       s_cyc;
        logic [1:0] mir;
        logic [2:0] e0;
        logic [2:0] e1;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic [1:0] cyc, input logic [2:0] sl, input logic sc,
                                input logic [1:0] mir, input logic [2:0] e0, input logic [2:0] e1);
        vec_t v;
        v.cyc = cyc; v.sl = sl; v.s_cyc = sc; v.mir = mir; v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    function automatic logic [64:0] bus_exp(input logic [1:0] mir);
        case (mir)
            2'd1:    return {m0_we_i, m0_adr_i, m0_sel_i, m0_dat_i};
            2'd2:    return {m1_we_i, m1_adr_i, m1_sel_i, m1_dat_i};
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] cyc, input logic [2:0] sl);
        m0_cyc_i = cyc[0]; m0_stb_i = cyc[0];
        m1_cyc_i = cyc[1]; m1_stb_i = cyc[1];
        s_ack_i = sl[2]; s_err_i = sl[1]; s_stall_i = sl[0];
    endtask

    task automatic rep(input int n, input vec_t v);
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        vec_t e;
        m0_we_i = 1'b1; m0_adr_i = 28'h00AAAA0; m0_sel_i = 4'h3; m0_dat_i = 32'h11111111;
        m1_we_i = 1'b0; m1_adr_i = 28'h0BBBB00; m1_sel_i = 4'hC; m1_dat_i = 32'h22222222;
        s_dat_i = 32'hDEADBEEF;
        drive(2'b00, 3'b000);

        // single m1 read, acked on the third BUSY cycle
        rep(1, mk(2'b10, 3'b000, 0, 0, 3'b001, 3'b001));
        rep(2, mk(2'b10, 3'b000, 1, 2, 3'b001, 3'b000));
        rep(1, mk(2'b10, 3'b100, 1, 2, 3'b001, 3'b100));
        rep(1, mk(2'b00, 3'b000, 0, 2, 3'b001, 3'b000));
        // tie -> m0, then m1 after one bubble, then tie -> m0 again
        rep(1, mk(2'b11, 3'b000, 0, 0, 3'b001, 3'b001));
        rep(1, mk(2'b11, 3'b000, 1, 1, 3'b000, 3'b001));
        rep(1, mk(2'b11, 3'b100, 1, 1, 3'b100, 3'b001));
        rep(1, mk(2'b10, 3'b000, 0, 1, 3'b000, 3'b001));
        rep(1, mk(2'b10, 3'b000, 0, 0, 3'b001, 3'b001));
        rep(1, mk(2'b10, 3'b000, 1, 2, 3'b001, 3'b000));
        rep(1, mk(2'b10, 3'b100, 1, 2, 3'b001, 3'b100));
        rep(1, mk(2'b00, 3'b000, 0, 2, 3'b001, 3'b000));
        rep(1, mk(2'b11, 3'b000, 0, 0, 3'b001, 3'b001));
        rep(1, mk(2'b11, 3'b000, 1, 1, 3'b000, 3'b001));
        rep(1, mk(2'b00, 3'b000, 0, 1, 3'b000, 3'b001));
        rep(1, mk(2'b00, 3'b000, 0, 0, 3'b001, 3'b001));
        // bus lock: m0 keeps cyc across three acks while m1 waits
        rep(1, mk(2'b01, 3'b000, 0, 0, 3'b001, 3'b001));
        rep(3, mk(2'b11, 3'b100, 1, 1, 3'b100, 3'b001));
        rep(1, mk(2'b10, 3'b000, 0, 1, 3'b000, 3'b001));
        rep(1, mk(2'b10, 3'b000, 0, 0, 3'b001, 3'b001));
        rep(1, mk(2'b10, 3'b100, 1, 2, 3'b001, 3'b100));
        rep(1, mk(2'b00, 3'b000, 0, 2, 3'b001, 3'b000));
        rep(1, mk(2'b00, 3'b000, 0, 0, 3'b001, 3'b001));
        // slave stall for 4 cycles
        rep(1, mk(2'b01, 3'b000, 0, 0, 3'b001, 3'b001));
        rep(4, mk(2'b01, 3'b001, 1, 1, 3'b001, 3'b001));
        rep(1, mk(2'b01, 3'b100, 1, 1, 3'b100, 3'b001));
        rep(1, mk(2'b00, 3'b000, 0, 1, 3'b000, 3'b001));
        rep(1, mk(2'b00, 3'b000, 0, 0, 3'b001, 3'b001));
        // timeout: 8 silent BUSY cycles then a one-cycle ABORT
        rep(1, mk(2'b10, 3'b000, 0, 0, 3'b001, 3'b001));
        rep(8, mk(2'b10, 3'b000, 1, 2, 3'b001, 3'b000));
        rep(1, mk(2'b10, 3'b000, 0, 3, 3'b001, 3'b011));
        rep(2, mk(2'b00, 3'b000, 0, 0, 3'b001, 3'b001));
        // ack on the 8th BUSY cycle keeps BUSY; a slave err follows
        rep(1, mk(2'b10, 3'b000, 0, 0, 3'b001, 3'b001));
        rep(7, mk(2'b10, 3'b000, 1, 2, 3'b001, 3'b000));
        rep(1, mk(2'b10, 3'b100, 1, 2, 3'b001, 3'b100));
        rep(1, mk(2'b10, 3'b010, 1, 2, 3'b001, 3'b010));
        rep(1, mk(2'b00, 3'b000, 0, 2, 3'b001, 3'b000));
        rep(1, mk(2'b00, 3'b000, 0, 0, 3'b001, 3'b001));

        @(negedge clk);
        #2;
        chk("reset s_cyc/stb", 65'({s_cyc_o, s_stb_o}), 65'(0));
        chk("reset s_bus", {s_we_o, s_adr_o, s_sel_o, s_dat_o}, 65'(0));
        chk("reset m0 a/e/s", 65'({m0_ack_o, m0_err_o, m0_stall_o}), 65'(3'b001));
        chk("reset m1 a/e/s", 65'({m1_ack_o, m1_err_o, m1_stall_o}), 65'(3'b001));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].cyc, vecs[i].sl);
            sb.push_back(vecs[i]);
            #2;
            e = sb.pop_front();
            chk($sformatf("v%0d s_cyc", i), 65'(s_cyc_o), 65'(e.s_cyc));
            chk($sformatf("v%0d s_stb", i), 65'(s_stb_o), 65'(e.s_cyc));
            chk($sformatf("v%0d m0 a/e/s", i), 65'({m0_ack_o, m0_err_o, m0_stall_o}), 65'(e.e0));
            chk($sformatf("v%0d m1 a/e/s", i), 65'({m1_ack_o, m1_err_o, m1_stall_o}), 65'(e.e1));
            chk($sformatf("v%0d m0/m1 dat", i), 65'({m0_dat_o, m1_dat_o}), 65'({2{32'hDEADBEEF}}));
            if (e.mir != 2'd3)
                chk($sformatf("v%0d s_bus", i), {s_we_o, s_adr_o, s_sel_o, s_dat_o}, bus_exp(e.mir));
        end

        // async reset between edges while m0 owns the bus
        @(negedge clk);
        drive(2'b01, 3'b000);
        @(negedge clk);
        #1;
        chk("pre-rst s_cyc", 65'(s_cyc_o), 65'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("async rst s_cyc/stb", 65'({s_cyc_o, s_stb_o}), 65'(0));
        chk("async rst stalls", 65'({m0_stall_o, m1_stall_o}), 65'(2'b11));
        @(negedge clk);
        rst = 1'b0;
        drive(2'b11, 3'b000);
        #2;
        chk("post-rst idle s_cyc", 65'(s_cyc_o), 65'(0));
        @(negedge clk);
        #2;
        chk("post-rst tie s_cyc", 65'(s_cyc_o), 65'(1));
        chk("post-rst tie bus m0", {s_we_o, s_adr_o, s_sel_o, s_dat_o}, bus_exp(2'd1));
        chk("post-rst m1 stall", 65'(m1_stall_o), 65'(1));
        @(negedge clk);
        drive(2'b00, 3'b000);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
